// File: rtl/ampm_clock_display_if.sv
// Control inputs and display/time outputs of the 12-hour AM/PM clock.
// The master drives the set controls; the slave (the clock) drives the display.
interface ampm_clock_display_if;
    logic       set_en;
    logic       hour_inc;
    logic       min_inc;
    logic [6:0] seg;
    logic [4:0] dig_sel;
    logic       colon;
    logic [3:0] hour;
    logic [5:0] minute;
    logic       pm;

    modport master (
        output set_en, hour_inc, min_inc,
        input  seg, dig_sel, colon, hour, minute, pm
    );

    modport slave (
        input  set_en, hour_inc, min_inc,
        output seg, dig_sel, colon, hour, minute, pm
    );
endinterface

// File: rtl/ampm_clock_display.sv
// 12-hour time-of-day clock with AM/PM, button setting and a scanned
// five-digit seven-segment display (HH MM plus an A/P letter).
module ampm_clock_display #(
    parameter int unsigned CLK_DIV        = 50_000_000,
    parameter int unsigned SCAN_DIV       = 50_000,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ampm_clock_display_if.slave    bus
);

    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_P     = 7'b1100111;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    logic [PW-1:0] r_presc;
    logic [5:0]    r_sec;
    logic [5:0]    r_min;
    logic [3:0]    r_hour;
    logic          r_pm;
    logic          r_hinc_prev;
    logic          r_minc_prev;
    logic [SW-1:0] r_scan_cnt;
    logic [2:0]    r_idx;
    logic [6:0]    r_seg;
    logic [4:0]    r_dig;
    logic          r_colon;

    logic       w_tick;
    logic       w_hour_rise;
    logic       w_min_rise;
    logic [3:0] w_hour_next;
    logic       w_pm_flip;
    logic [5:0] w_min_next;
    logic [3:0] w_hour_ones;
    logic [3:0] w_min_tens;
    logic [3:0] w_min_ones;
    logic [6:0] w_seg;
    logic [4:0] w_dig;

    assign w_tick      = !bus.set_en && (r_presc == PRESC_MAX);
    assign w_hour_rise = bus.hour_inc && !r_hinc_prev;
    assign w_min_rise  = bus.min_inc && !r_minc_prev;
    assign w_hour_next = (r_hour == 4'd12) ? 4'd1 : r_hour + 4'd1;
    assign w_pm_flip   = (r_hour == 4'd11);
    assign w_min_next  = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc     <= '0;
            r_sec       <= 6'd0;
            r_min       <= 6'd0;
            r_hour      <= 4'd12;
            r_pm        <= 1'b0;
            r_hinc_prev <= 1'b1;
            r_minc_prev <= 1'b1;
        end else begin
            r_hinc_prev <= bus.hour_inc;
            r_minc_prev <= bus.min_inc;
            if (bus.set_en) begin
                // Setting freezes the seconds so counting restarts cleanly on exit.
                r_presc <= '0;
                r_sec   <= 6'd0;
                if (w_min_rise) begin
                    r_min <= w_min_next;
                end
                if (w_hour_rise) begin
                    r_hour <= w_hour_next;
                    if (w_pm_flip) begin
                        r_pm <= ~r_pm;
                    end
                end
            end else if (w_tick) begin
                r_presc <= '0;
                if (r_sec == 6'd59) begin
                    r_sec <= 6'd0;
                    r_min <= w_min_next;
                    if (r_min == 6'd59) begin
                        r_hour <= w_hour_next;
                        if (w_pm_flip) begin
                            r_pm <= ~r_pm;
                        end
                    end
                end else begin
                    r_sec <= r_sec + 6'd1;
                end
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= 3'd0;
        end else if (r_scan_cnt == SCAN_MAX) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // Decimal split without dividers: hour is 1..12, minute 0..59.
    always_comb begin
        w_hour_ones = (r_hour >= 4'd10) ? 4'(r_hour - 4'd10) : r_hour;
        w_min_tens  = 4'd0;
        w_min_ones  = r_min[3:0];
        if (r_min >= 6'd50) begin
            w_min_tens = 4'd5;
            w_min_ones = 4'(r_min - 6'd50);
        end else if (r_min >= 6'd40) begin
            w_min_tens = 4'd4;
            w_min_ones = 4'(r_min - 6'd40);
        end else if (r_min >= 6'd30) begin
            w_min_tens = 4'd3;
            w_min_ones = 4'(r_min - 6'd30);
        end else if (r_min >= 6'd20) begin
            w_min_tens = 4'd2;
            w_min_ones = 4'(r_min - 6'd20);
        end else if (r_min >= 6'd10) begin
            w_min_tens = 4'd1;
            w_min_ones = 4'(r_min - 6'd10);
        end
    end

    always_comb begin
        w_seg = SEG_BLANK;
        case (r_idx)
            3'd0:    w_seg = (r_hour >= 4'd10) ? f_seg(4'd1) : SEG_BLANK;
            3'd1:    w_seg = f_seg(w_hour_ones);
            3'd2:    w_seg = f_seg(w_min_tens);
            3'd3:    w_seg = f_seg(w_min_ones);
            3'd4:    w_seg = r_pm ? SEG_P : SEG_A;
            default: w_seg = SEG_BLANK;
        endcase
    end

    assign w_dig = 5'b00001 << r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg   <= {7{SEG_ACTIVE_LOW}};
            r_dig   <= {5{SEG_ACTIVE_LOW}};
            r_colon <= SEG_ACTIVE_LOW;
        end else begin
            r_seg   <= w_seg ^ {7{SEG_ACTIVE_LOW}};
            r_dig   <= w_dig ^ {5{SEG_ACTIVE_LOW}};
            r_colon <= (bus.set_en | ~r_sec[0]) ^ SEG_ACTIVE_LOW;
        end
    end

    assign bus.seg     = r_seg;
    assign bus.dig_sel = r_dig;
    assign bus.colon   = r_colon;
    assign bus.hour    = r_hour;
    assign bus.minute  = r_min;
    assign bus.pm      = r_pm;

endmodule

// File: tb/tb_ampm_clock_display.sv
// Bench for ampm_clock_display: vector table, corner sequences and random
// stimulus checked every cycle against a seconds-of-day reference model.
module tb_ampm_clock_display;

    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned SCAN_DIV = 2;
    localparam logic [6:0]  SEG_A    = 7'b1110111;
    localparam logic [6:0]  SEG_P    = 7'b1100111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ampm_clock_display_if bus();

    ampm_clock_display #(
        .CLK_DIV        (CLK_DIV),
        .SCAN_DIV       (SCAN_DIV),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] seg_lut [10];

    // Reference model: time kept as seconds since midnight (0..86399).
    int         t;
    int         m_cnt;
    int         m_cyc;
    logic       m_hprev, m_mprev;
    logic [6:0] exp_seg;
    logic [4:0] exp_dig;
    logic       exp_colon;

    function automatic int m_hour();
        int h12 = (t / 3600) % 12;
        return (h12 == 0) ? 12 : h12;
    endfunction
    function automatic int m_min();
        return (t / 60) % 60;
    endfunction
    function automatic int m_sec();
        return t % 60;
    endfunction
    function automatic int m_pm();
        return (t >= 43200) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("hour",    int'(bus.hour),    m_hour());
        chk("minute",  int'(bus.minute),  m_min());
        chk("pm",      int'(bus.pm),      m_pm());
        chk("seg",     int'(bus.seg),     int'(exp_seg));
        chk("dig_sel", int'(bus.dig_sel), int'(exp_dig));
        chk("colon",   int'(bus.colon),   int'(exp_colon));
    endtask

    task automatic model_reset();
        t = 0; m_cnt = 0; m_cyc = 0;
        m_hprev = 1'b1; m_mprev = 1'b1;
        exp_seg = 7'd0; exp_dig = 5'd0; exp_colon = 1'b0;
    endtask

    // Predict this edge's display and counter effect, then clock and compare.
    task automatic step();
        int  idx, h, mi;
        logic hr, mr;
        idx = (m_cyc / SCAN_DIV) % 5;
        h   = m_hour();
        mi  = m_min();
        case (idx)
            0:       exp_seg = (h >= 10) ? seg_lut[1] : 7'd0;
            1:       exp_seg = seg_lut[h % 10];
            2:       exp_seg = seg_lut[mi / 10];
            3:       exp_seg = seg_lut[mi % 10];
            default: exp_seg = (m_pm() != 0) ? SEG_P : SEG_A;
        endcase
        exp_dig   = 5'(1 << idx);
        exp_colon = bus.set_en ? 1'b1 : (m_sec() % 2 == 0);
        hr = bus.hour_inc && !m_hprev;
        mr = bus.min_inc && !m_mprev;
        if (bus.set_en) begin
            m_cnt = 0;
            t = t - m_sec();
            if (mr) t = (m_min() == 59) ? t - 59 * 60 : t + 60;
            if (hr) t = (t + 3600) % 86400;
        end else if (m_cnt == CLK_DIV - 1) begin
            m_cnt = 0;
            t = (t + 1) % 86400;
        end else begin
            m_cnt++;
        end
        m_hprev = bus.hour_inc;
        m_mprev = bus.min_inc;
        m_cyc++;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic pulse(input logic h, input logic m);
        bus.hour_inc = h; bus.min_inc = m;
        step();
        bus.hour_inc = 1'b0; bus.min_inc = 1'b0;
        step();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_time(input int h, input int mi, input int want_pm);
        bus.set_en = 1'b1;
        for (int i = 0; i < 24 && !(m_hour() == h && m_pm() == want_pm); i++) pulse(1'b1, 1'b0);
        for (int i = 0; i < 60 && m_min() != mi; i++) pulse(1'b0, 1'b1);
    endtask

    task automatic wait_dig(input string name, input logic [4:0] want);
        bit found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (bus.dig_sel == want) found = 1'b1;
        end
        chk(name, int'(found), 1);
    endtask

    task automatic do_reset(input logic hold_set, input logic hold_h);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        bus.set_en = hold_set; bus.hour_inc = hold_h; bus.min_inc = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all();
    endtask

    typedef struct {
        logic set_en;
        logic hinc;
        logic minc;
        int   cycles;
        int   hour;
        int   minute;
        int   pm;
    } vec_t;

    vec_t vecs [12];

    initial begin
        seg_lut[0] = 7'b1111110; seg_lut[1] = 7'b0110000; seg_lut[2] = 7'b1101101;
        seg_lut[3] = 7'b1111001; seg_lut[4] = 7'b0110011; seg_lut[5] = 7'b1011011;
        seg_lut[6] = 7'b1011111; seg_lut[7] = 7'b1110000; seg_lut[8] = 7'b1111111;
        seg_lut[9] = 7'b1111011;

        vecs[0]  = '{1'b1, 1'b1, 1'b0,   1,  1,  0, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0,   1,  1,  0, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1,  10,  1,  1, 0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0,   1,  1,  1, 0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1,   1,  2,  2, 0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0,   1,  2,  2, 0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1,   1,  2,  2, 0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0,   1,  2,  2, 0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0,   1,  3,  2, 0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0,   1,  3,  2, 0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 240,  3,  3, 0};
        vecs[11] = '{1'b1, 1'b0, 1'b0,   1,  3,  3, 0};

        bus.set_en = 1'b0; bus.hour_inc = 1'b0; bus.min_inc = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        check_all();
        run(12);

        for (int i = 0; i < 12; i++) begin
            bus.set_en = vecs[i].set_en; bus.hour_inc = vecs[i].hinc; bus.min_inc = vecs[i].minc;
            run(vecs[i].cycles);
            chk($sformatf("vec%0d_hour", i),   int'(bus.hour),   vecs[i].hour);
            chk($sformatf("vec%0d_minute", i), int'(bus.minute), vecs[i].minute);
            chk($sformatf("vec%0d_pm", i),     int'(bus.pm),     vecs[i].pm);
        end
        bus.hour_inc = 1'b0; bus.min_inc = 1'b0;

        // 11:59 AM plus 60 ticks rolls to 12:00 PM.
        set_time(11, 59, 0);
        bus.set_en = 1'b0;
        run(240);
        chk("am_pm_hour", int'(bus.hour), 12);
        chk("am_pm_min",  int'(bus.minute), 0);
        chk("am_pm_pm",   int'(bus.pm), 1);
        wait_dig("wait_letter", 5'b10000);
        chk("letter_p", int'(bus.seg), int'(SEG_P));

        // 12:59 PM plus 60 ticks gives 1:00 PM with a blank hour-tens digit.
        set_time(12, 59, 1);
        bus.set_en = 1'b0;
        run(240);
        chk("one_pm_hour", int'(bus.hour), 1);
        chk("one_pm_min",  int'(bus.minute), 0);
        chk("one_pm_pm",   int'(bus.pm), 1);
        wait_dig("wait_htens", 5'b00001);
        chk("htens_blank", int'(bus.seg), 0);

        // Sixty minute pulses wrap with no hour carry; a held button counts once.
        bus.set_en = 1'b1;
        for (int i = 0; i < 60; i++) pulse(1'b0, 1'b1);
        chk("min_wrap_min",  int'(bus.minute), 0);
        chk("min_wrap_hour", int'(bus.hour), 1);
        bus.min_inc = 1'b1;
        run(10);
        bus.min_inc = 1'b0;
        step();
        chk("min_hold", int'(bus.minute), 1);

        // Buttons are ignored while running.
        bus.set_en = 1'b0;
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b1);
        chk("ignored_hour", int'(bus.hour), 1);
        chk("ignored_min",  int'(bus.minute), 1);

        // Simultaneous edges at 11:59 PM land on 12:00 AM.
        set_time(11, 59, 1);
        pulse(1'b1, 1'b1);
        chk("both_hour", int'(bus.hour), 12);
        chk("both_min",  int'(bus.minute), 0);
        chk("both_pm",   int'(bus.pm), 0);

        // 11:59:59 PM tick gives 12:00:00 AM.
        set_time(11, 59, 1);
        bus.set_en = 1'b0;
        run(240);
        chk("pm_am_hour", int'(bus.hour), 12);
        chk("pm_am_pm",   int'(bus.pm), 0);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) bus.set_en = ~bus.set_en;
            bus.hour_inc = ($urandom_range(0, 3) == 0);
            bus.min_inc  = ($urandom_range(0, 3) == 0);
            step();
        end

        // Asynchronous reset mid-run with the button held through release.
        do_reset(1'b1, 1'b1);
        run(5);
        chk("held_release_hour", int'(bus.hour), 12);
        bus.hour_inc = 1'b0;
        step();
        bus.hour_inc = 1'b1;
        step();
        chk("after_release_hour", int'(bus.hour), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ampm_clock_display.md
# ampm_clock_display

Parametrised 12-hour time-of-day clock with AM/PM indication, driving a multiplexed five-digit seven-segment display (HH MM plus an A/P letter digit). It counts seconds from a divided system clock, supports hour/minute setting from synchronous push-button inputs, and scans the display digits itself. It sits between the board clock and the seven-segment pins, in place of the single-letter AM/PM indicator.

## Interface
Parameters:
- CLK_DIV, 50_000_000: clk cycles per one-second tick (≥2).
- SCAN_DIV, 50_000: clk cycles per display digit slot (≥1).
- SEG_ACTIVE_LOW, 0: 1 inverts all seg and dig_sel bits at the output register.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- set_en  in  1  time-set mode; synchronous to clk.
- hour_inc  in  1  hour-advance request; synchronous, rising-edge detected.
- min_inc  in  1  minute-advance request; synchronous, rising-edge detected.
- seg  out  7  segments {a,b,c,d,e,f,g}, seg[6]=a … seg[0]=g; registered.
- dig_sel  out  5  one-hot digit enable: bit0 hour tens, bit1 hour ones, bit2 minute tens, bit3 minute ones, bit4 A/P letter; registered.
- colon  out  1  colon LED; registered.
- hour  out  4  current hour, 1..12.
- minute  out  6  current minute, 0..59.
- pm  out  1  0 = AM, 1 = PM.

## Operation
- Reset (async, rst_n=0): hour=12, minute=0, seconds=0, pm=0, prescaler=0, scan index=0, seg=blank, dig_sel=none (all inactive), colon=0, hour_inc/min_inc previous-sample registers=1.
- Prescaler counts 0..CLK_DIV-1; tick asserted on the cycle it equals CLK_DIV-1, then wraps to 0.
- On tick (set_en=0): seconds+1; 59→0 carries to minute; minute 59→0 carries to hour.
- Hour advance (carry or set): 11→12 toggles pm; 12→1 does not toggle; otherwise +1.
- set_en=1: prescaler and seconds held at 0, no ticks; rising edge (current=1, previous=0) of hour_inc advances hour (pm rule applies); rising edge of min_inc advances minute, 59→0 with no hour carry. Both edges same cycle: both applied.
- set_en=0: hour_inc/min_inc ignored (previous-sample registers still track).
- set_en falling: counting resumes from seconds=0, prescaler=0.
- Scan: counter 0..SCAN_DIV-1; at wrap, scan index advances 0→1→2→3→4→0.
- Digit content: 0 = hour tens (blank if hour<10, else '1'); 1 = hour ones; 2 = minute tens; 3 = minute ones; 4 = 'A' (1110111) if pm=0, 'P' (1100111) if pm=1.
- Digit codes (abcdefg): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, blank=0000000.
- colon = 1 when seconds even, 0 when odd; colon = 1 steady while set_en=1.
- SEG_ACTIVE_LOW=1: seg, dig_sel, colon inverted at output; reset values inverted likewise.

## Timing
- hour/minute/pm are the counter registers: change on the edge where tick (or set edge) is sampled.
- Set latency: inc input high at edge N, low at edge N-1 → counter updated after edge N.
- Display outputs registered one cycle behind scan index and counters: first edge after reset release drives dig_sel=00001 with hour-tens content.
- Full rollover 11:59:59 AM tick → 12:00:00 PM in one edge; 11:59:59 PM → 12:00:00 AM.
- Input held high through reset release: no increment (previous register reset to 1).

## Test plan
- Reset, CLK_DIV=4, SCAN_DIV=2: after release hour=12, minute=0, pm=0; dig_sel cycles 00001,00010,00100,01000,10000 every 2 clocks with seg 0110000,1101101,1111110,1111110,1110111.
- Set hour to 11, minute to 59, run 60 ticks (240 clocks) → hour=12, minute=0, pm=1; letter digit seg=1100111.
- From 12:59 set_en=0, 60 ticks → hour=1, minute=0, pm unchanged; hour-tens digit blank.
- set_en=1, pulse min_inc 60 times from minute=0 → minute=0, hour unchanged; hold min_inc high 10 cycles → single increment.
- hour_inc/min_inc pulses with set_en=0 → no change; both rising same cycle with set_en=1 at 11:59 → 12:00, pm toggled.
- Assert rst_n mid-count and mid-scan → all outputs return to reset values immediately, without a clock edge.
